// File: rtl/intbus_debug_init_pkg.sv
// Shared types for the intbus debug initiator: FSM states, response record and
// the saturating increment used by the optional statistics counters.
package intbus_debug_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        RESP
    } state_t;

    localparam int STAT_W     = 16;
    localparam int RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  tmo;
    } rsp_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/intbus_debug_init_tmr.sv
// Loadable down-counter bounding how long a read waits for bus_rvalid.
// expired is high while the count sits at zero.
module intbus_debug_init_tmr #(
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TMO_CYC + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(TMO_CYC);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/intbus_debug_init.sv
// Debug initiator: turns single read/write commands into intbus strobes and
// returns read data or a timeout. Optional counters: INTBUS_DEBUG_INIT_STATS_EN.
module intbus_debug_init
    import intbus_debug_init_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_tmo,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wr,
    output logic              bus_rd,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid
`ifdef INTBUS_DEBUG_INIT_STATS_EN
   ,input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_tmo_cnt
`endif
);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    rsp_t              rsp_q,       rsp_d;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_expired;

    intbus_debug_init_tmr #(
        .TMO_CYC (TMO_CYC)
    ) u_tmr (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rsp_d       = rsp_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    bus_addr_d  = cmd_addr;
                    bus_wdata_d = cmd_wdata;
                    state_d     = cmd_wr ? WR : RD;
                end
            end
            WR: begin
                rsp_d   = '0;
                state_d = RESP;
            end
            RD: begin
                tmr_load = 1'b1;
                state_d  = RWAIT;
            end
            RWAIT: begin
                // rvalid is checked first so it wins over a same-cycle expiry
                if (bus_rvalid) begin
                    rsp_d.rdata = RSP_DATA_W'(bus_rdata);
                    rsp_d.tmo   = 1'b0;
                    state_d     = RESP;
                end else if (tmr_expired) begin
                    rsp_d     = '0;
                    rsp_d.tmo = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_q       <= rsp_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign bus_wr    = (state_q == WR);
    assign bus_rd    = (state_q == RD);
    assign rsp_valid = (state_q == RESP);
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign rsp_tmo   = rsp_q.tmo;

`ifdef INTBUS_DEBUG_INIT_STATS_EN
    logic [STAT_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic [STAT_W-1:0] rd_cnt_q,  rd_cnt_d;
    logic [STAT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic              tmo_evt;

    assign tmo_evt = (state_q == RWAIT) && !bus_rvalid && tmr_expired;

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        if (stat_clr) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            tmo_cnt_d = '0;
        end else begin
            if (bus_wr)  wr_cnt_d  = sat_inc(wr_cnt_q);
            if (bus_rd)  rd_cnt_d  = sat_inc(rd_cnt_q);
            if (tmo_evt) tmo_cnt_d = sat_inc(tmo_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_tmo_cnt = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_intbus_debug_init.sv
// Scoreboard bench for intbus_debug_init: directed commands push expected
// responses, a monitor pops and compares them when rsp_valid is presented.
module tb_intbus_debug_init;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_tmo;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
`ifdef INTBUS_DEBUG_INIT_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_tmo_cnt;
`endif

    intbus_debug_init #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .TMO_CYC (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_tmo    (rsp_tmo),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid)
`ifdef INTBUS_DEBUG_INIT_STATS_EN
       ,.stat_clr     (stat_clr),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_tmo_cnt (stat_tmo_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          slave_lat  = 0;
    logic [31:0] slave_data = '0;
    int          stray_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: answers bus_rd after slave_lat cycles (0 = never), plus stray pulses
    initial begin
        int lat_cnt = 0;
        int stray_seen = 0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            bus_rdata  = '0;
            if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                bus_rvalid = 1'b1;
                bus_rdata  = 32'hBADBAD00;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = slave_data;
                end
            end
            if (bus_rd && slave_lat > 0) lat_cnt = slave_lat;
        end
    end

    // Monitor: compares every presented response cycle against the queue head
    initial begin
        bit seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL rsp_unexpected: got rsp_valid=1, expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb_q[0];
                    if (!seen) begin
                        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                        seen = 1;
                    end
                    check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
                    check("rsp_tmo", {63'h0, rsp_tmo}, {63'h0, e.tmo});
                    check("cmd_ready_in_resp", {63'h0, cmd_ready}, 64'h0);
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                                 input logic push, input logic [31:0] exp_rdata, input logic exp_tmo,
                                 input int lat, output int n);
        bit ok = 0;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("cmd_accept", {63'h0, cmd_ready}, 64'h1);
            cmd_valid = 1'b0;
            n = -1;
            return;
        end
        n = cyc;
        if (push) begin
            e.rdata = exp_rdata;
            e.tmo   = exp_tmo;
            e.cyc   = cyc + lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check(wr ? "bus_wr_strobe" : "bus_rd_strobe", {63'h0, wr ? bus_wr : bus_rd}, 64'h1);
        check("bus_other_strobe", {63'h0, wr ? bus_rd : bus_wr}, 64'h0);
        check("bus_addr", {48'h0, bus_addr}, {48'h0, addr});
        if (wr) check("bus_wdata", {32'h0, bus_wdata}, {32'h0, data});
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drain", 64'(sb_q.size()), 64'h0);
    endtask

    task automatic checkOutput_allZero(input string tag);
        check({tag, "_cmd_ready"}, {63'h0, cmd_ready}, 64'h0);
        check({tag, "_rsp_valid"}, {63'h0, rsp_valid}, 64'h0);
        check({tag, "_bus_wr"},    {63'h0, bus_wr},    64'h0);
        check({tag, "_bus_rd"},    {63'h0, bus_rd},    64'h0);
        check({tag, "_bus_addr"},  {48'h0, bus_addr},  64'h0);
        check({tag, "_bus_wdata"}, {32'h0, bus_wdata}, 64'h0);
        check({tag, "_rsp_rdata"}, {32'h0, rsp_rdata}, 64'h0);
        check({tag, "_rsp_tmo"},   {63'h0, rsp_tmo},   64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int r;
        bit got;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
`ifdef INTBUS_DEBUG_INIT_STATS_EN
        stat_clr  = 1'b0;
`endif
        #2;
        checkOutput_allZero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        $display("[TB] write 0x0040");
        applyStimulus(1'b1, 16'h0040, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2, n);
        @(negedge clk);
        check("bus_wr_one_cycle", {63'h0, bus_wr}, 64'h0);
        check("bus_addr_hold", {48'h0, bus_addr}, 64'h0040);
        waitDrain();

        $display("[TB] read latency 3");
        slave_lat  = 3;
        slave_data = 32'h12345678;
        applyStimulus(1'b0, 16'h0080, 32'h0, 1'b1, 32'h12345678, 1'b0, 5, n);
        @(negedge clk);
        check("bus_rd_one_cycle", {63'h0, bus_rd}, 64'h0);
        waitDrain();

        $display("[TB] timeout with backpressure and stray rvalid");
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        slave_lat = 0;
        applyStimulus(1'b0, 16'h00C0, 32'h0, 1'b1, 32'h0, 1'b1, 7, n);
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        check("tmo_rsp_seen", {63'h0, got}, 64'h1);
        stray_cnt++;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        r = cyc;
        applyStimulus(1'b1, 16'h0100, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 2, n);
        check("b2b_accept_cycle", 64'(n), 64'(r + 1));
        waitDrain();

        $display("[TB] reset during RWAIT");
        slave_lat = 0;
        applyStimulus(1'b0, 16'h0200, 32'h0, 1'b0, 32'h0, 1'b0, 0, n);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput_allZero("midreset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        $display("[TB] traffic mix 3 writes, 2 reads, 1 timeout");
        applyStimulus(1'b1, 16'h0010, 32'h00000001, 1'b1, 32'h0, 1'b0, 2, n);
        waitDrain();
        applyStimulus(1'b1, 16'h0014, 32'h00000002, 1'b1, 32'h0, 1'b0, 2, n);
        waitDrain();
        applyStimulus(1'b1, 16'h0018, 32'h00000003, 1'b1, 32'h0, 1'b0, 2, n);
        waitDrain();
        slave_lat  = 1;
        slave_data = 32'hA5A55A5A;
        applyStimulus(1'b0, 16'h001C, 32'h0, 1'b1, 32'hA5A55A5A, 1'b0, 3, n);
        waitDrain();
        slave_lat = 0;
        applyStimulus(1'b0, 16'h0020, 32'h0, 1'b1, 32'h0, 1'b1, 7, n);
        waitDrain();
`ifdef INTBUS_DEBUG_INIT_STATS_EN
        @(negedge clk);
        check("stat_wr_cnt",  {48'h0, stat_wr_cnt},  64'd3);
        check("stat_rd_cnt",  {48'h0, stat_rd_cnt},  64'd2);
        check("stat_tmo_cnt", {48'h0, stat_tmo_cnt}, 64'd1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_clr_wr",  {48'h0, stat_wr_cnt},  64'd0);
        check("stat_clr_rd",  {48'h0, stat_rd_cnt},  64'd0);
        check("stat_clr_tmo", {48'h0, stat_tmo_cnt}, 64'd0);
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
